// File: rtl/car_draw_scheduler_pkg.sv
// Shared constants, FSM state encoding and a width helper for the car scheduler.
package car_draw_scheduler_pkg;

  localparam int DEF_NUM_CARS     = 8;
  localparam int DEF_FRAME_CYCLES = 833334;  // 60 Hz at 50 MHz
  localparam int DEF_SPAWN_GAP    = 30;
  localparam int DEF_WATCHDOG     = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_FRAME,
    S_SCAN,
    S_GRANT,
    S_SETTLE,
    S_WAIT_DONE
  } sched_state_e;

  // Bits needed to hold values 0..v-1, never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/car_draw_scheduler_frame_timer.sv
// Free-running frame counter; tick is high in the wrap cycle.
module car_draw_scheduler_frame_timer
  import car_draw_scheduler_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
  input  logic clk,
  input  logic reset,
  output logic frame_tick_o
);

  localparam int FW = clog2(FRAME_CYCLES);
  localparam logic [FW-1:0] LAST = FW'(FRAME_CYCLES - 1);

  logic [FW-1:0] cnt_q, cnt_d;

  // Count up and wrap at the last cycle of the frame.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + FW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign frame_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/car_draw_scheduler.sv
// Stage master: starts a stage, releases cars on a spawn schedule and hands
// out one VGA turn per waiting car per frame, strictly in index order.
module car_draw_scheduler
  import car_draw_scheduler_pkg::*;
#(
  parameter int NUM_CARS     = DEF_NUM_CARS,
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int SPAWN_GAP    = DEF_SPAWN_GAP,
  parameter int WATCHDOG     = DEF_WATCHDOG
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stage_start,
  input  logic [NUM_CARS-1:0] car_wait_draw,
  input  logic [NUM_CARS-1:0] car_destroyed_state,
  output logic                initiate,
  output logic [NUM_CARS-1:0] initial_delay_done,
  output logic [NUM_CARS-1:0] enable_draw,
  output logic                frame_tick,
  output logic                stage_active,
  output logic                stage_clear,
  output logic                frame_overrun,
  output logic                watchdog_err
);

  localparam int IW        = clog2(NUM_CARS + 1);
  localparam int WW        = clog2(WATCHDOG + 1);
  localparam int SPAWN_MAX = (NUM_CARS - 1) * SPAWN_GAP;
  localparam int SW        = clog2(SPAWN_MAX + 1);

  sched_state_e        state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [WW-1:0]       wd_q, wd_d;
  logic [SW-1:0]       spawn_q, spawn_d;
  logic [NUM_CARS-1:0] idd_q, idd_d;
  logic                active_q, active_d;
  logic                clear_q, clear_d;
  logic                ovr_q, ovr_d;
  logic                wderr_q, wderr_d;

  logic sel_wait, sel_dead, busy, wd_expired, all_dead;

  car_draw_scheduler_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .frame_tick_o(frame_tick)
  );

  // Pick the handshake bits of the car currently addressed by idx.
  always_comb begin
    sel_wait = 1'b0;
    sel_dead = 1'b0;
    for (int i = 0; i < NUM_CARS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_wait = car_wait_draw[i];
        sel_dead = car_destroyed_state[i];
      end
    end
  end

  assign all_dead   = &car_destroyed_state;
  assign wd_expired = (wd_q >= WW'(WATCHDOG));
  assign busy       = (state_q == S_SCAN) || (state_q == S_GRANT) ||
                      (state_q == S_SETTLE) || (state_q == S_WAIT_DONE);

  // Next-state logic for the grant FSM, watchdog and sticky flags.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wd_d     = wd_q;
    active_d = active_q;
    clear_d  = 1'b0;
    ovr_d    = ovr_q | (frame_tick & busy);  // tick mid-pass is dropped, not queued
    wderr_d  = wderr_q;
    case (state_q)
      S_IDLE: begin
        if (stage_start) begin
          state_d  = S_START;
          active_d = 1'b1;
        end
      end
      S_START: begin
        state_d = S_WAIT_FRAME;
        idx_d   = '0;
        ovr_d   = 1'b0;
        wderr_d = 1'b0;
      end
      S_WAIT_FRAME: begin
        // Clear has priority over a coincident tick.
        if (active_q && all_dead) begin
          clear_d  = 1'b1;
          active_d = 1'b0;
          state_d  = S_IDLE;
        end else if (frame_tick) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (idx_q == IW'(NUM_CARS)) state_d = S_WAIT_FRAME;
        else if (sel_wait)          state_d = S_GRANT;
        else                        idx_d   = idx_q + IW'(1);
      end
      S_GRANT: begin
        state_d = S_SETTLE;
        wd_d    = WW'(1);
      end
      S_SETTLE: begin
        state_d = S_WAIT_DONE;
        wd_d    = wd_q + WW'(1);
      end
      S_WAIT_DONE: begin
        wd_d = wd_q + WW'(1);
        if (sel_wait || sel_dead) begin
          state_d = S_SCAN;
          idx_d   = idx_q + IW'(1);
        end else if (wd_expired) begin
          wderr_d = 1'b1;
          state_d = S_SCAN;
          idx_d   = idx_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Spawn frame counter and latched per-car release bits.
  always_comb begin
    spawn_d = spawn_q;
    idd_d   = idd_q;
    if (state_q == S_START) begin
      spawn_d  = '0;
      idd_d    = '0;
      idd_d[0] = 1'b1;
    end else if (active_q) begin
      if (frame_tick && (spawn_q != SW'(SPAWN_MAX))) spawn_d = spawn_q + SW'(1);
      for (int i = 0; i < NUM_CARS; i++)
        if (int'(spawn_q) >= i * SPAWN_GAP) idd_d[i] = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wd_q     <= '0;
      spawn_q  <= '0;
      idd_q    <= '0;
      active_q <= 1'b0;
      clear_q  <= 1'b0;
      ovr_q    <= 1'b0;
      wderr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wd_q     <= wd_d;
      spawn_q  <= spawn_d;
      idd_q    <= idd_d;
      active_q <= active_d;
      clear_q  <= clear_d;
      ovr_q    <= ovr_d;
      wderr_q  <= wderr_d;
    end
  end

  // One-hot grant decoded from the register, so reset kills it immediately.
  always_comb begin
    enable_draw = '0;
    if (state_q == S_GRANT)
      for (int i = 0; i < NUM_CARS; i++)
        if (idx_q == IW'(i)) enable_draw[i] = 1'b1;
  end

  assign initiate           = (state_q == S_START);
  assign initial_delay_done = idd_q;
  assign stage_active       = active_q;
  assign stage_clear        = clear_q;
  assign frame_overrun      = ovr_q;
  assign watchdog_err       = wderr_q;

endmodule

// File: tb/tb_car_draw_scheduler.sv
// Bench for car_draw_scheduler with three modelled car controllers.
module tb_car_draw_scheduler;

  localparam int NC = 3;
  localparam int FC = 100;
  localparam int SG = 2;
  localparam int WD = 50;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stage_start = 1'b0;
  logic [NC-1:0] car_wait_draw = '0;
  logic [NC-1:0] car_destroyed_state = '0;
  logic [NC-1:0] initial_delay_done, enable_draw;
  logic initiate, frame_tick, stage_active, stage_clear, frame_overrun, watchdog_err;

  car_draw_scheduler #(.NUM_CARS(NC), .FRAME_CYCLES(FC), .SPAWN_GAP(SG), .WATCHDOG(WD)) dut (
    .clk                (clk),
    .reset              (reset),
    .stage_start        (stage_start),
    .car_wait_draw      (car_wait_draw),
    .car_destroyed_state(car_destroyed_state),
    .initiate           (initiate),
    .initial_delay_done (initial_delay_done),
    .enable_draw        (enable_draw),
    .frame_tick         (frame_tick),
    .stage_active       (stage_active),
    .stage_clear        (stage_clear),
    .frame_overrun      (frame_overrun),
    .watchdog_err       (watchdog_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t0, t1, t2;     // turn length of each car
    logic [2:0] dm;     // cars held destroyed
    int w1, w2;         // grants in frame windows after tick 6 and tick 7
    int s0, s1, s2;     // expected grant order in first window
    logic wd, ovr;      // expected sticky flags
  } vec_t;

  vec_t vt[4];
  int n_vec = 0, n_err = 0;
  int cyc = 0, ntick = 0, nclr = 0, novl = 0, wd_lat = -1, last_g1 = 0;
  int last_tick = 0, tick_per = 0;
  int turn[NC];
  int cnt[NC];
  logic [NC-1:0] destroy = '0;
  logic wd_prev = 1'b0;
  int gtick[$];
  int gidx[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Car controller models: leave the wait state for turn[i] cycles after a grant.
  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (reset) cnt[i] = 0;
      else if (enable_draw[i]) cnt[i] = turn[i];
      else if (cnt[i] > 0) cnt[i] = cnt[i] - 1;
      car_wait_draw[i] = initial_delay_done[i] && (cnt[i] == 0) && !destroy[i];
    end
    car_destroyed_state = destroy;
  end

  // Observer: ticks, grants (tagged with tick number), overlaps, clears, watchdog latency.
  always @(negedge clk) begin
    if (frame_tick) begin
      tick_per = cyc - last_tick;
      last_tick = cyc;
      ntick++;
    end
    if (stage_clear) nclr++;
    if ($countones(enable_draw) > 1) novl++;
    else if (enable_draw != '0) begin
      for (int i = 0; i < NC; i++) if (enable_draw[i]) begin
        gtick.push_back(ntick);
        gidx.push_back(i);
        if (i == 1) last_g1 = cyc;
      end
    end
    if (watchdog_err && !wd_prev) wd_lat = cyc - last_g1;
    wd_prev = watchdog_err;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ticks(input int target);
    int b;
    b = 0;
    while (ntick < target && b < 2000) begin
      @(negedge clk);
      b++;
    end
    if (ntick < target) begin
      n_vec++;
      n_err++;
      $display("FAIL tick_timeout: got %0d ticks expected %0d", ntick, target);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) stage_start = 1'b1;
    @(negedge clk) stage_start = 1'b0;
  endtask

  task automatic run_vec(input int v);
    int base, w1, w2;
    int es[3];
    int seq[$];
    do_reset();
    turn[0] = vt[v].t0; turn[1] = vt[v].t1; turn[2] = vt[v].t2;
    destroy = vt[v].dm;
    es[0] = vt[v].s0; es[1] = vt[v].s1; es[2] = vt[v].s2;
    gtick.delete(); gidx.delete();
    novl = 0; wd_lat = -1;
    pulse_start();
    base = ntick;
    wait_ticks(base + 8);
    w1 = 0; w2 = 0;
    for (int k = 0; k < gtick.size(); k++) begin
      if (gtick[k] == base + 6) begin w1++; seq.push_back(gidx[k]); end
      else if (gtick[k] == base + 7) w2++;
    end
    chk($sformatf("v%0d_grants_w1", v), w1, vt[v].w1);
    chk($sformatf("v%0d_grants_w2", v), w2, vt[v].w2);
    for (int k = 0; k < seq.size() && k < vt[v].w1 && k < 3; k++)
      chk($sformatf("v%0d_order%0d", v, k), seq[k], es[k]);
    chk($sformatf("v%0d_watchdog_err", v), watchdog_err, vt[v].wd);
    chk($sformatf("v%0d_frame_overrun", v), frame_overrun, vt[v].ovr);
    chk($sformatf("v%0d_overlap", v), novl, 0);
    if (vt[v].wd) chk($sformatf("v%0d_wd_latency_in_50_51(lat=%0d)", v, wd_lat),
                      (wd_lat >= 50 && wd_lat <= 51), 1);
  endtask

  initial begin
    int base, nb, bad, b;
    vt[0] = '{20, 20, 20, 3'b000, 3, 3, 0, 1, 2, 1'b0, 1'b0};
    vt[1] = '{10, 60, 10, 3'b000, 3, 3, 0, 1, 2, 1'b1, 1'b0};
    vt[2] = '{40, 40, 40, 3'b000, 3, 0, 0, 1, 2, 1'b0, 1'b1};
    vt[3] = '{ 5,  5,  5, 3'b010, 2, 2, 0, 2, 0, 1'b0, 1'b0};
    for (int i = 0; i < NC; i++) turn[i] = 20;

    // Reset state
    cycles(3);
    chk("reset_outputs", {initiate, initial_delay_done, enable_draw, frame_tick,
                          stage_active, stage_clear, frame_overrun, watchdog_err}, 0);
    reset = 1'b0;
    cycles(2);

    // Stage start and spawn schedule
    pulse_start();
    chk("initiate_high", initiate, 1);
    chk("idd_in_start", initial_delay_done, 3'b000);
    chk("stage_active_start", stage_active, 1);
    base = ntick;
    @(negedge clk);
    chk("initiate_one_cycle", initiate, 0);
    chk("idd_car0_next", initial_delay_done, 3'b001);
    wait_ticks(base + 1); cycles(3);
    chk("idd_tick1", initial_delay_done, 3'b001);
    wait_ticks(base + 2); cycles(3);
    chk("idd_tick2", initial_delay_done, 3'b011);
    wait_ticks(base + 3); cycles(3);
    chk("idd_tick3", initial_delay_done, 3'b011);
    wait_ticks(base + 4); cycles(3);
    chk("idd_tick4", initial_delay_done, 3'b111);
    chk("tick_period", tick_per, FC);

    // stage_start while active is ignored
    pulse_start();
    chk("start_ignored", initiate, 0);

    // Destroy all cars: single clear pulse, release bits stay latched
    nb = nclr;
    destroy = 3'b111;
    b = 0;
    while (stage_active && b < 400) begin @(negedge clk); b++; end
    cycles(5);
    chk("clear_pulses", nclr - nb, 1);
    chk("stage_active_after_clear", stage_active, 0);
    chk("idd_latched_after_clear", initial_delay_done, 3'b111);

    // Restart from IDLE
    destroy = 3'b000;
    pulse_start();
    chk("restart_initiate", initiate, 1);
    @(negedge clk);
    chk("restart_idd", initial_delay_done, 3'b001);
    chk("restart_flags", {frame_overrun, watchdog_err}, 0);

    // Reset asserted while a grant is out
    b = 0;
    while (enable_draw == '0 && b < 400) begin @(negedge clk); b++; end
    chk("grant_seen_before_reset", (enable_draw != '0), 1);
    #1 reset = 1'b1;
    #1;
    chk("reset_kills_grant", enable_draw, 0);
    chk("reset_mid_outputs", {initiate, initial_delay_done, enable_draw, frame_tick,
                              stage_active, stage_clear, frame_overrun, watchdog_err}, 0);
    cycles(2);
    reset = 1'b0;
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (enable_draw != '0 || initiate || stage_active || initial_delay_done != '0) bad++;
    end
    chk("idle_after_reset", bad, 0);

    // Table-driven frame scenarios
    for (int v = 0; v < 4; v++) run_vec(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
